trisc1: RTL
===========

TRISC1 -- requirements
Module: trisc1

Interface
REQ-001 Parameter DW, default 8, data/stack word width (>=4).
REQ-002 Parameter AW, default 8, program/data address width and instruction argument width.
REQ-003 Parameter SD, default 4, operand stack depth (>=2).
REQ-004 Parameter RD, default 2, return stack depth (>=1).
REQ-005 The module SHALL have these ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- pm_addr  out  AW  program address (= pc).
- pm_data  in  5+AW  instruction {op[4:0], arg[AW-1:0]}, read combinationally.
- dm_addr  out  AW  data address (= arg).
- dm_rdata  in  DW  data read, combinational.
- dm_wdata  out  DW  data write value (= s0).
- dm_we  out  1  write enable, sampled on rising edge.
- iport  in  DW  input data.
- in_valid  in  1  iport valid.
- in_ready  out  1  one-cycle consume pulse.
- oport  out  DW  registered output data.
- out_valid  out  1  one-cycle output pulse.
- s0_out, s1_out  out  DW  top two stack words.
- depth  out  log2(SD+1)  operand stack occupancy.
- run_state  out  2  00 RUN, 01 HALT, 10 ERR.
- jc_out  out  1  jump condition flag.
- err_code  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 return-stack fault.

Function
REQ-006 The module SHALL execute one instruction per clock in RUN, except for a scan stall; single-cycle latency from pm_data to architectural update.
REQ-007 Opcodes SHALL be: 0 add, 1 neg, 2 sub (s1-s0), 3 and, 4 or, 5 inv, 6 mul, 7 pop (dm[arg]<=s0), 8 pushi, 9 push (dm[arg]), 10 scan, 11 print, 12 cne, 13 ceq, 14 cjp, 15 jmp, 16 call, 17 ret, 18 dup, 19 swap, 20 halt; 21-31 nop.
REQ-008 Arithmetic SHALL wrap modulo 2^DW; mul keeps the low DW bits of the signed product; pushi sign-extends or truncates arg to DW.
REQ-009 Binary ops (add, sub, and, or, mul) SHALL need depth>=2, write s0 and pop one entry (depth-1, bottom word filled with 0).
REQ-010 Unary ops (neg, inv, dup-source, print, pop) SHALL need depth>=1; neg/inv keep depth; dup SHALL push s0 (needs depth<SD); swap SHALL need depth>=2.
REQ-011 pushi, push, scan and dup SHALL require depth<SD, else overflow.
REQ-012 pop and print SHALL drop s0 (depth-1); pop SHALL assert dm_we for that cycle only.
REQ-013 ceq/cne SHALL need depth>=2, set jc to (s0==s1)/(s0!=s1), and not change the stack; every other executed op leaves jc unchanged.
REQ-014 cjp SHALL load pc<=arg when jc==0, else pc+1; jmp SHALL load pc<=arg unconditionally; other ops pc+1 with wrap at 2^AW.
REQ-015 call SHALL push pc+1 on the return stack and jump to arg; ret SHALL pop pc; call when full or ret when empty SHALL give err_code 11.
REQ-016 scan SHALL stall (pc and stack held) while in_valid=0; on the in_valid=1 cycle it SHALL push iport and pulse in_ready.
REQ-017 print SHALL register oport<=s0 and pulse out_valid one cycle; oport holds otherwise.
REQ-018 Fault checks SHALL precede the stall: a faulting instruction SHALL enter ERR, set err_code, and update no pc/stack/memory/port state.
REQ-019 halt SHALL enter HALT; HALT and ERR SHALL be absorbing until reset, with dm_we, in_ready and out_valid held 0.

Reset
REQ-020 Reset SHALL asynchronously clear pc, both stacks, depth, return pointer, jc, oport, out_valid, in_ready and err_code to 0 and set run_state RUN, including when asserted mid-stall or in ERR/HALT.

Verification (DW=8, AW=8, SD=4, RD=2)
REQ-021 pushi 5, pushi 3, sub -> s0=2, depth=1, pc=3.
REQ-022 pushi 100, pushi 3, mul -> s0=0x2C, depth=1.
REQ-023 Five pushi -> after fifth: run_state=ERR, err_code=01, depth=4, pc=4 frozen.
REQ-024 scan with in_valid low 3 cycles, then high with iport=0x7F -> pc held 3 cycles, single in_ready pulse, s0=0x7F.
REQ-025 call 0x10 at pc 2, ret at 0x10 -> pc=3; a further ret -> ERR, err_code=11.
REQ-026 pushi 7, pushi 7, ceq, cjp 0x20 -> jc=1, pc=4, depth=2; then print -> oport=7, one out_valid pulse, depth=1.

Source files
------------

// File: rtl/trisc1.sv
// TRISC1: single-cycle stack processor with operand/return stacks, a data memory port,
// and blocking scan / pulsed print I/O. One instruction retires per clock in RUN.
module trisc1 #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int SD = 4,
  parameter int RD = 2,
  localparam int DPW = $clog2(SD + 1),
  localparam int RPW = $clog2(RD + 1)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [AW-1:0]   pm_addr,
  input  logic [4+AW:0]   pm_data,
  output logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_rdata,
  output logic [DW-1:0]   dm_wdata,
  output logic            dm_we,
  input  logic [DW-1:0]   iport,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   oport,
  output logic            out_valid,
  output logic [DW-1:0]   s0_out,
  output logic [DW-1:0]   s1_out,
  output logic [DPW-1:0]  depth,
  output logic [1:0]      run_state,
  output logic            jc_out,
  output logic [1:0]      err_code
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_NEG  = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4,  OP_INV  = 5'd5,  OP_MUL  = 5'd6,  OP_POP  = 5'd7;
  localparam logic [4:0] OP_PUSHI = 5'd8, OP_PUSH = 5'd9,  OP_SCAN = 5'd10, OP_PRINT = 5'd11;
  localparam logic [4:0] OP_CNE  = 5'd12, OP_CEQ  = 5'd13, OP_CJP  = 5'd14, OP_JMP  = 5'd15;
  localparam logic [4:0] OP_CALL = 5'd16, OP_RET  = 5'd17, OP_DUP  = 5'd18, OP_SWAP = 5'd19;
  localparam logic [4:0] OP_HALT = 5'd20;

  localparam logic [DPW-1:0] SD_L = DPW'(SD);
  localparam logic [RPW-1:0] RD_L = RPW'(RD);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DPW-1:0]  depth_q, depth_d;
  logic [RPW-1:0]  rp_q, rp_d;
  logic            jc_q, jc_d;
  logic [DW-1:0]   oport_q, oport_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      err_q, err_d;
  logic [DW-1:0]   stk_q [SD];
  logic [DW-1:0]   stk_d [SD];
  logic [AW-1:0]   rstk_q [RD];
  logic [AW-1:0]   rstk_d [RD];

  logic [4:0]      op;
  logic [AW-1:0]   arg;
  logic            need1, need2, grow;
  logic            under, over, rsf, fault, stall, exec;
  logic            push_en, pop_en, bin_en;
  logic [DW-1:0]   push_val, bin_res;
  logic [AW-1:0]   pc_inc, ret_pc;

  function automatic logic [DW-1:0] sext_arg(input logic [AW-1:0] a);
    return DW'($signed(a));
  endfunction

  function automatic logic [DW-1:0] mul_lo(input logic signed [DW-1:0] a,
                                           input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = (2*DW)'(a) * (2*DW)'(b);
    return p[DW-1:0];
  endfunction

  always_comb begin
    op       = pm_data[4+AW -: 5];
    arg      = pm_data[AW-1:0];
    pc_inc   = pc_q + AW'(1);
    need1    = 1'b0;
    need2    = 1'b0;
    grow     = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL,
      OP_CNE, OP_CEQ, OP_SWAP:            need2 = 1'b1;
      OP_NEG, OP_INV, OP_POP, OP_PRINT:   need1 = 1'b1;
      OP_DUP:                             begin need1 = 1'b1; grow = 1'b1; end
      OP_PUSHI, OP_PUSH, OP_SCAN:         grow  = 1'b1;
      default: ;
    endcase
    ret_pc = '0;
    for (int i = 0; i < RD; i++)
      if (rp_q == RPW'(i + 1)) ret_pc = rstk_q[i];

    under = (need2 && depth_q < DPW'(2)) || (need1 && depth_q == '0);
    over  = grow && depth_q == SD_L;
    rsf   = (op == OP_CALL && rp_q == RD_L) || (op == OP_RET && rp_q == '0);
    // Faults are judged before the scan stall so an overflowing scan errors immediately.
    fault = (state_q == ST_RUN) && (under || over || rsf);
    stall = (state_q == ST_RUN) && !fault && op == OP_SCAN && !in_valid;
    exec  = (state_q == ST_RUN) && !fault && !stall;

    state_d     = state_q;
    pc_d        = pc_q;
    depth_d     = depth_q;
    rp_d        = rp_q;
    jc_d        = jc_q;
    oport_d     = oport_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    stk_d       = stk_q;
    rstk_d      = rstk_q;
    push_en     = 1'b0;
    pop_en      = 1'b0;
    bin_en      = 1'b0;
    push_val    = '0;
    bin_res     = '0;

    if (fault) begin
      state_d = ST_ERR;
      err_d   = under ? 2'b10 : (over ? 2'b01 : 2'b11);
    end else if (exec) begin
      pc_d = pc_inc;
      case (op)
        OP_ADD:   begin bin_en = 1'b1; bin_res = stk_q[1] + stk_q[0]; end
        OP_SUB:   begin bin_en = 1'b1; bin_res = stk_q[1] - stk_q[0]; end
        OP_AND:   begin bin_en = 1'b1; bin_res = stk_q[1] & stk_q[0]; end
        OP_OR:    begin bin_en = 1'b1; bin_res = stk_q[1] | stk_q[0]; end
        OP_MUL:   begin bin_en = 1'b1; bin_res = mul_lo(stk_q[1], stk_q[0]); end
        OP_NEG:   stk_d[0] = -stk_q[0];
        OP_INV:   stk_d[0] = ~stk_q[0];
        OP_POP:   pop_en = 1'b1;
        OP_PUSHI: begin push_en = 1'b1; push_val = sext_arg(arg); end
        OP_PUSH:  begin push_en = 1'b1; push_val = dm_rdata; end
        OP_SCAN:  begin push_en = 1'b1; push_val = iport; end
        OP_DUP:   begin push_en = 1'b1; push_val = stk_q[0]; end
        OP_PRINT: begin pop_en = 1'b1; oport_d = stk_q[0]; out_valid_d = 1'b1; end
        OP_CNE:   jc_d = (stk_q[0] != stk_q[1]);
        OP_CEQ:   jc_d = (stk_q[0] == stk_q[1]);
        OP_CJP:   pc_d = jc_q ? pc_inc : arg;
        OP_JMP:   pc_d = arg;
        OP_CALL: begin
          for (int i = 0; i < RD; i++)
            if (rp_q == RPW'(i)) rstk_d[i] = pc_inc;
          rp_d = rp_q + RPW'(1);
          pc_d = arg;
        end
        OP_RET:   begin pc_d = ret_pc; rp_d = rp_q - RPW'(1); end
        OP_SWAP:  begin stk_d[0] = stk_q[1]; stk_d[1] = stk_q[0]; end
        OP_HALT:  state_d = ST_HALT;
        default: ;
      endcase

      // Shrinking ops shift the stack toward s0 and zero-fill the bottom slot.
      if (bin_en || pop_en) begin
        for (int i = 0; i < SD - 1; i++) stk_d[i] = stk_q[i + 1];
        stk_d[SD-1] = '0;
        if (bin_en) stk_d[0] = bin_res;
        depth_d = depth_q - DPW'(1);
      end
      if (push_en) begin
        for (int i = 1; i < SD; i++) stk_d[i] = stk_q[i - 1];
        stk_d[0] = push_val;
        depth_d  = depth_q + DPW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      depth_q     <= '0;
      rp_q        <= '0;
      jc_q        <= 1'b0;
      oport_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 2'b00;
      for (int i = 0; i < SD; i++) stk_q[i] <= '0;
      for (int i = 0; i < RD; i++) rstk_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      rp_q        <= rp_d;
      jc_q        <= jc_d;
      oport_q     <= oport_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      stk_q       <= stk_d;
      rstk_q      <= rstk_d;
    end
  end

  assign pm_addr   = pc_q;
  assign dm_addr   = arg;
  assign dm_wdata  = stk_q[0];
  assign dm_we     = !reset && exec && op == OP_POP;
  assign in_ready  = !reset && exec && op == OP_SCAN;
  assign oport     = oport_q;
  assign out_valid = out_valid_q;
  assign s0_out    = stk_q[0];
  assign s1_out    = stk_q[1];
  assign depth     = depth_q;
  assign run_state = state_q;
  assign jc_out    = jc_q;
  assign err_code  = err_q;

endmodule
